// File: rtl/i2s_clkgen_ctrl.sv
// I2S master clock generator: gates MCLK, derives BCLK/LRCLK from one frame counter,
// and sequences ADC config changes through a clock-stop hold and a settle wait.
module i2s_clkgen_ctrl #(
    parameter int FS_RATIO_LOG2 = 8,
    parameter int BCLK_LOG2     = 6,
    parameter int HOLD_CYCLES   = 1024,
    parameter int SETTLE_LOG2   = 22
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       cfg_valid_i,
    input  logic       cfg_fmt_i,
    input  logic [1:0] cfg_sf_i,
    output logic       cfg_ready_o,
    output logic       mclk_en_o,
    output logic       bclk_o,
    output logic       lrclk_o,
    output logic       bclk_fall_o,
    output logic       frame_start_o,
    output logic       devices_ready_o,
    output logic       fmt_o,
    output logic       sf0_o,
    output logic       sf1_o
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BB = FS_RATIO_LOG2 - BCLK_LOG2 - 1;
    localparam int LB = FS_RATIO_LOG2 - 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_HOLD, S_SETTLE, S_READY} state_t;

    state_t                   state_q, state_d;
    logic [HW-1:0]            hold_q, hold_d;
    logic [SETTLE_LOG2-1:0]   settle_q, settle_d;
    logic [FS_RATIO_LOG2-1:0] frame_q, frame_d;
    logic                     accept;
    logic                     bclk_fall_q, frame_start_q, dev_rdy_q;
    logic                     fmt_q, sf0_q, sf1_q;

    assign cfg_ready_o = (state_q != S_HOLD);
    assign mclk_en_o   = (state_q != S_HOLD);
    assign accept      = cfg_valid_i && cfg_ready_o;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        settle_d = settle_q;
        case (state_q)
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_SETTLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (&settle_q) begin
                    state_d  = S_READY;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_READY: ;
            default: state_d = S_HOLD;
        endcase
        // An accepted config always restarts the full stop/settle sequence.
        if (accept) begin
            state_d  = S_HOLD;
            hold_d   = '0;
            settle_d = '0;
        end
        frame_d = (state_q == S_HOLD || state_d == S_HOLD) ? '0 : frame_q + 1'b1;
    end

    // devices_ready_o first rises HOLD_CYCLES + 2**SETTLE_LOG2 + 1 cycles after reset release.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q       <= S_HOLD;
            hold_q        <= '0;
            settle_q      <= '0;
            frame_q       <= '0;
            bclk_fall_q   <= 1'b0;
            frame_start_q <= 1'b0;
            dev_rdy_q     <= 1'b0;
            fmt_q         <= 1'b0;
            sf0_q         <= 1'b0;
            sf1_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            settle_q      <= settle_d;
            frame_q       <= frame_d;
            bclk_fall_q   <= (state_d != S_HOLD) && frame_q[BB] && !frame_d[BB];
            frame_start_q <= (state_d != S_HOLD) && frame_q[LB] && !frame_d[LB];
            dev_rdy_q     <= (state_q == S_READY) && !accept;
            if (accept) begin
                fmt_q <= cfg_fmt_i;
                sf0_q <= cfg_sf_i[0];
                sf1_q <= cfg_sf_i[1];
            end
        end
    end

    assign bclk_o          = frame_q[BB];
    assign lrclk_o         = frame_q[LB];
    assign bclk_fall_o     = bclk_fall_q;
    assign frame_start_o   = frame_start_q;
    assign devices_ready_o = dev_rdy_q;
    assign fmt_o           = fmt_q;
    assign sf0_o           = sf0_q;
    assign sf1_o           = sf1_q;

endmodule

// File: tb/tb_i2s_clkgen_ctrl.sv
// Bench for i2s_clkgen_ctrl: a time-since-restart reference model checked every cycle,
// a config vector table, reset/latency sequences and randomized config traffic.
module tb_i2s_clkgen_ctrl;

    localparam int H      = 16;
    localparam int SL     = 6;
    localparam int SETTLE = 1 << SL;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_fmt = 1'b0;
    logic [1:0] cfg_sf = 2'b00;
    logic       cfg_ready, mclk_en, bclk, lrclk, bclk_fall, frame_start;
    logic       devices_ready, fmt, sf0, sf1;

    always #5 clk = ~clk;

    i2s_clkgen_ctrl #(
        .FS_RATIO_LOG2(8),
        .BCLK_LOG2    (6),
        .HOLD_CYCLES  (H),
        .SETTLE_LOG2  (SL)
    ) dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_fmt_i      (cfg_fmt),
        .cfg_sf_i       (cfg_sf),
        .cfg_ready_o    (cfg_ready),
        .mclk_en_o      (mclk_en),
        .bclk_o         (bclk),
        .lrclk_o        (lrclk),
        .bclk_fall_o    (bclk_fall),
        .frame_start_o  (frame_start),
        .devices_ready_o(devices_ready),
        .fmt_o          (fmt),
        .sf0_o          (sf0),
        .sf1_o          (sf1)
    );

    typedef struct {
        int         at;
        logic       fmt;
        logic [1:0] sf;
        logic [2:0] exp_pins;
    } vec_t;

    vec_t tbl[5];
    int   n_cmp = 0;
    int   n_bad = 0;
    // Model: cycles since last restart (reset release or accepted config) plus latched pins.
    int         m_t = 0;
    logic       m_fmt = 1'b0;
    logic [1:0] m_sf = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t t=%0d act=%0h exp=%0h", name, $time, m_t, act, exp);
        end
    endtask

    task automatic check_model();
        bit run;
        int p;
        run = (m_t >= H);
        p   = m_t - H;
        chk("mclk_en", mclk_en, run);
        chk("cfg_ready", cfg_ready, run);
        chk("bclk", bclk, run && (p % 4 >= 2));
        chk("lrclk", lrclk, run && (p % 256 >= 128));
        chk("bclk_fall", bclk_fall, (m_t > H) && (p % 4 == 0));
        chk("frame_start", frame_start, (m_t > H) && (p % 256 == 0));
        chk("devices_ready", devices_ready, m_t >= H + SETTLE + 1);
        chk("pins", {fmt, sf1, sf0}, {m_fmt, m_sf});
    endtask

    task automatic step();
        @(posedge clk);
        if (arst_n) begin
            if (cfg_valid && m_t >= H) begin
                m_t   = 0;
                m_fmt = cfg_fmt;
                m_sf  = cfg_sf;
            end else begin
                m_t++;
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (m_t != target && n < 2000) begin
            step();
            n++;
        end
        if (m_t != target) chk("run_to_timeout", m_t, target);
    endtask

    task automatic measure_latency();
        int n;
        n = 0;
        while (!mclk_en && n < 300) begin
            step();
            n++;
        end
        chk("mclk_en_latency", n, H);
        while (!devices_ready && n < 300) begin
            step();
            n++;
        end
        chk("ready_latency", n, H + SETTLE + 1);
    endtask

    initial begin
        tbl[0] = '{at: 85,  fmt: 1'b1, sf: 2'b10, exp_pins: 3'b110}; // accept in READY
        tbl[1] = '{at: 5,   fmt: 1'b0, sf: 2'b01, exp_pins: 3'b110}; // ignored in HOLD
        tbl[2] = '{at: 30,  fmt: 1'b0, sf: 2'b01, exp_pins: 3'b001}; // accept in SETTLE
        tbl[3] = '{at: 30,  fmt: 1'b0, sf: 2'b11, exp_pins: 3'b011}; // second accept in SETTLE
        tbl[4] = '{at: 120, fmt: 1'b1, sf: 2'b00, exp_pins: 3'b100};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {cfg_ready, mclk_en, bclk, lrclk, bclk_fall, frame_start,
                              devices_ready, fmt, sf1, sf0}, 10'd0);
        arst_n = 1'b1;
        m_t = 0;

        foreach (tbl[i]) begin
            run_to(tbl[i].at);
            cfg_valid = 1'b1;
            cfg_fmt   = tbl[i].fmt;
            cfg_sf    = tbl[i].sf;
            step();
            cfg_valid = 1'b0;
            chk("vec_pins", {fmt, sf1, sf0}, tbl[i].exp_pins);
        end
        measure_latency();

        // Asynchronous reset mid-frame in READY.
        run_to(200);
        #2 arst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {cfg_ready, mclk_en, bclk, lrclk, bclk_fall, frame_start,
                                    devices_ready, fmt, sf1, sf0}, 10'd0);
        m_t   = 0;
        m_fmt = 1'b0;
        m_sf  = 2'b00;
        repeat (2) step();
        arst_n = 1'b1;
        measure_latency();

        // Randomized config traffic, including offers while held.
        for (int k = 0; k < 3000; k++) begin
            cfg_valid = ($urandom_range(0, 119) == 0);
            cfg_fmt   = 1'($urandom_range(0, 1));
            cfg_sf    = 2'($urandom_range(0, 3));
            step();
        end
        cfg_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
